// File: rtl/latch_bank_write_arbiter.sv
// ============================================================================
// Module   : latch_bank_write_arbiter
// Brief    : Round-robin write arbiter and SETUP/ENABLE/HOLD sequencer for a
//            shared bank of level-sensitive D latches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_bank_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*WIDTH-1:0]  i_wdata,
    input  logic [N_REQ*AW-1:0]     i_waddr,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_done,
    output logic [WIDTH-1:0]        o_latch_d,
    output logic [(1<<AW)-1:0]      o_latch_en,
    output logic                    o_busy
);

    localparam int DEPTH = 1 << AW;
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAXC0 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAXC  = (MAXC0 > HOLD_CYC) ? MAXC0 : HOLD_CYC;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]    C_SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0]    C_EN_LAST    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0]    C_HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [N_REQ-1:0] C_GRANT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] C_EN_ONE     = {{(DEPTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ENABLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [N_REQ-1:0]   r_done, w_done_nxt;
    logic [WIDTH-1:0]   r_latch_d, w_latch_d_nxt;
    logic [DEPTH-1:0]   r_latch_en, w_latch_en_nxt;
    logic [AW-1:0]      r_addr, w_addr_nxt;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
    logic [N_REQ-1:0]   w_req_hi;
    logic               w_hi_found, w_any_found;
    logic [PW-1:0]      w_hi_win, w_any_win, w_win;
    logic [WIDTH-1:0]   w_sel_data;
    logic [AW-1:0]      w_sel_addr;

    always_comb begin
        w_req_hi    = '0;
        w_hi_found  = 1'b0;
        w_any_found = 1'b0;
        w_hi_win    = '0;
        w_any_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_req_hi[i] = i_req[i] && (PW'(i) >= r_ptr);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_hi_found = 1'b1;
                w_hi_win   = PW'(i);
            end
            if (i_req[i]) begin
                w_any_found = 1'b1;
                w_any_win   = PW'(i);
            end
        end
        w_win = w_hi_found ? w_hi_win : w_any_win;
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_sel_data = i_wdata[i*WIDTH +: WIDTH];
                w_sel_addr = i_waddr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_done_nxt     = '0;
        w_latch_d_nxt  = r_latch_d;
        w_latch_en_nxt = '0;
        w_addr_nxt     = r_addr;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_any_found) begin
                    w_state_nxt   = S_SETUP;
                    w_cnt_nxt     = C_SETUP_LAST;
                    w_grant_nxt   = C_GRANT_ONE << w_win;
                    w_latch_d_nxt = w_sel_data;
                    w_addr_nxt    = w_sel_addr;
                    w_ptr_nxt     = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt    = S_ENABLE;
                    w_cnt_nxt      = C_EN_LAST;
                    w_latch_en_nxt = C_EN_ONE << r_addr;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ENABLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD_LAST;
                    w_done_nxt  = (HOLD_CYC == 1) ? r_grant : '0;
                end else begin
                    w_cnt_nxt      = r_cnt - 1'b1;
                    w_latch_en_nxt = r_latch_en;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end else begin
                    w_cnt_nxt  = r_cnt - 1'b1;
                    // Done lands in the final HOLD cycle, i.e. when the count will be 0.
                    w_done_nxt = (r_cnt == CW'(1)) ? r_grant : '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_latch_d  <= '0;
            r_latch_en <= '0;
            r_addr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_latch_d  <= w_latch_d_nxt;
            r_latch_en <= w_latch_en_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    assign o_grant    = r_grant;
    assign o_done     = r_done;
    assign o_latch_d  = r_latch_d;
    assign o_latch_en = r_latch_en;
    assign o_busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_latch_bank_write_arbiter.sv
// ============================================================================
// Module   : tb_latch_bank_write_arbiter
// Brief    : Directed self-checking bench for latch_bank_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latch_bank_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [7:0]  waddr;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  latch_d;
    logic [3:0]  latch_en;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    latch_bank_write_arbiter #(
        .N_REQ(4), .WIDTH(8), .AW(2), .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_wdata    (wdata),
        .i_waddr    (waddr),
        .o_grant    (grant),
        .o_done     (done),
        .o_latch_d  (latch_d),
        .o_latch_en (latch_en),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous stability and one-hot monitoring.
    logic [7:0] prev_d;
    logic [3:0] prev_en;
    logic       prev_rst;
    always @(negedge clk) begin
        if (!rst && !prev_rst) begin
            if (latch_en != 4'd0 || prev_en != 4'd0)
                check("d_stable", {24'd0, latch_d}, {24'd0, prev_d});
            check("en_onehot0", {31'd0, $onehot0(latch_en)}, 32'd1);
            check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
        end
        prev_d   <= latch_d;
        prev_en  <= latch_en;
        prev_rst <= rst;
    end

    initial begin
        logic [3:0] exp_done;
        rst = 1'b1; req = 4'd0; wdata = 32'd0; waddr = 8'd0;
        tick(); tick();
        check("rst_grant", {28'd0, grant}, 32'h0);
        check("rst_done", {28'd0, done}, 32'h0);
        check("rst_en", {28'd0, latch_en}, 32'h0);
        check("rst_d", {24'd0, latch_d}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        tick();

        // Single write: requester 0, data A5, word 2.
        req = 4'b0001; wdata = 32'h000000A5; waddr = 8'b00_00_00_10;
        tick();
        check("t1_grant_c1", {28'd0, grant}, 32'h1);
        check("t1_d_c1", {24'd0, latch_d}, 32'hA5);
        check("t1_busy_c1", {31'd0, busy}, 32'h1);
        check("t1_en_c1", {28'd0, latch_en}, 32'h0);
        tick();
        check("t1_en_c2", {28'd0, latch_en}, 32'h4);
        tick();
        check("t1_en_c3", {28'd0, latch_en}, 32'h4);
        check("t1_done_c3", {28'd0, done}, 32'h0);
        tick();
        check("t1_done_c4", {28'd0, done}, 32'h1);
        check("t1_en_c4", {28'd0, latch_en}, 32'h0);
        req = 4'b0000;
        tick();
        check("t1_busy_c5", {31'd0, busy}, 32'h0);
        check("t1_grant_c5", {28'd0, grant}, 32'h0);
        check("t1_d_c5", {24'd0, latch_d}, 32'hA5);

        // Reset to restart the pointer at 0.
        rst = 1'b1; tick(); rst = 1'b0; tick();

        // All four requesters together; each drops Req with its own Done.
        req = 4'b1111; wdata = 32'h44332211; waddr = 8'b11_10_01_00;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp_done = 4'd0;
            if (c == 4 || c == 9 || c == 14 || c == 19) exp_done = 4'd1 << ((c - 4) / 5);
            check("t2_done", {28'd0, done}, {28'd0, exp_done});
            if (c == 1 || c == 6 || c == 11 || c == 16) begin
                check("t2_grant", {28'd0, grant}, 32'd1 << ((c - 1) / 5));
                check("t2_d", {24'd0, latch_d}, 32'h11 * (((c - 1) / 5) + 1));
            end
            if (c == 2 || c == 7 || c == 12 || c == 17)
                check("t2_en", {28'd0, latch_en}, 32'd1 << ((c - 2) / 5));
            if (c == 5 || c == 10 || c == 15 || c == 20)
                check("t2_idle", {31'd0, busy}, 32'h0);
            req = req & ~exp_done;
        end

        // Pointer wrapped to 0: requesters 0 and 3 compete, 0 wins first.
        req = 4'b1001;
        tick();
        check("t3_grant0", {28'd0, grant}, 32'h1);
        check("t3_d0", {24'd0, latch_d}, 32'h11);
        tick(); tick(); tick();
        check("t3_done0", {28'd0, done}, 32'h1);
        req = 4'b1000;
        tick();
        check("t3_idle", {31'd0, busy}, 32'h0);
        tick();
        check("t3_grant3", {28'd0, grant}, 32'h8);
        check("t3_d3", {24'd0, latch_d}, 32'h44);
        tick();
        check("t3_en3", {28'd0, latch_en}, 32'h8);
        tick(); tick();
        check("t3_done3", {28'd0, done}, 32'h8);
        req = 4'b0000;
        tick();

        // Inputs change during ENABLE are ignored.
        req = 4'b0001; wdata = 32'h443322A5; waddr = 8'b11_10_01_10;
        tick();
        check("t4_grant", {28'd0, grant}, 32'h1);
        tick();
        check("t4_en_c2", {28'd0, latch_en}, 32'h4);
        wdata = 32'h4433223C; req = 4'b0000;
        tick();
        check("t4_d_c3", {24'd0, latch_d}, 32'hA5);
        check("t4_en_c3", {28'd0, latch_en}, 32'h4);
        tick();
        check("t4_done", {28'd0, done}, 32'h1);
        check("t4_d_c4", {24'd0, latch_d}, 32'hA5);
        tick();
        check("t4_d_c5", {24'd0, latch_d}, 32'hA5);
        check("t4_busy_c5", {31'd0, busy}, 32'h0);
        tick();
        check("t4_no_regrant", {28'd0, grant}, 32'h0);

        // Reset during the first ENABLE cycle.
        req = 4'b0001; wdata = 32'h443322A5;
        tick();
        check("t5_grant", {28'd0, grant}, 32'h1);
        tick();
        check("t5_en_pre", {28'd0, latch_en}, 32'h4);
        #2 rst = 1'b1;
        #1;
        check("t5_en_async", {28'd0, latch_en}, 32'h0);
        check("t5_grant_async", {28'd0, grant}, 32'h0);
        check("t5_busy_async", {31'd0, busy}, 32'h0);
        tick();
        check("t5_no_done", {28'd0, done}, 32'h0);
        tick();
        #2 rst = 1'b0;
        req = 4'b0011;
        tick();
        check("t5_grant_after", {28'd0, grant}, 32'h1);
        check("t5_d_after", {24'd0, latch_d}, 32'hA5);
        tick(); tick(); tick();
        check("t5_done_after", {28'd0, done}, 32'h1);
        req = 4'b0010;
        tick(); tick();
        check("t5_grant_next", {28'd0, grant}, 32'h2);
        check("t5_d_next", {24'd0, latch_d}, 32'h22);
        req = 4'b0000;
        tick(); tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/latch_bank_write_arbiter.md
Name: latch_bank_write_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared bank of level-sensitive D latches (2^AW words x WIDTH bits, one common D bus, one En line per word).
- Grants one of N_REQ requesters at a time.
- Drives the latch D bus and the selected word's En with a guaranteed setup / enable / hold phase sequence, so that D never changes while any En is high.
- Sits between the latch bank and the synchronous logic that writes it.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- WIDTH, 8, latch word width
- AW, 2, word address width; bank depth = 2^AW
- SETUP_CYC, 1, cycles D is stable before En rises (>=1)
- EN_CYC, 2, cycles En is held high (>=1)
- HOLD_CYC, 1, cycles D is held after En falls (>=1)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Req  input  N_REQ  per-requester write request, level
- Wdata  input  N_REQ*WIDTH  per-requester write data; requester i uses bits [i*WIDTH +: WIDTH]
- Waddr  input  N_REQ*AW  per-requester word address; requester i uses bits [i*AW +: AW]
- Grant  output  N_REQ  one-hot; high for the granted requester from SETUP through HOLD
- Done  output  N_REQ  one-cycle pulse to the granted requester in its last HOLD cycle
- Latch_D  output  WIDTH  shared latch data bus
- Latch_En  output  2^AW  one-hot latch word enable; all zero outside ENABLE
- Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, Grant=0, Done=0, Latch_En=0, Latch_D=0, Busy=0, round-robin pointer=0, phase counter=0. Latch_En drops immediately, even mid-ENABLE. Latch contents are not reset.
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE:
  - If Req != 0, select the first requester with Req set, searching from the pointer upward with wraparound.
  - Capture that requester's Wdata into Latch_D and its Waddr into an internal address register.
  - Set Grant one-hot, set the pointer to (winner+1) mod N_REQ, and go to SETUP.
  - If Req == 0, stay in IDLE with all outputs held at their previous values, except Grant, Done and Latch_En, which are 0.
- SETUP: lasts SETUP_CYC cycles, then ENABLE.
- ENABLE: Latch_En = 1 << addr for exactly EN_CYC cycles, then HOLD.
- HOLD: Latch_En=0 for HOLD_CYC cycles. Done[winner]=1 in the final HOLD cycle. Next state is IDLE.
- Latch_D changes only on the IDLE->SETUP transition. It holds its value through HOLD and after returning to IDLE, until the next grant.
- Latch_En is registered and glitch-free. It is never high in SETUP, HOLD or IDLE.
- A single phase counter counts down from each phase length minus 1. The transition occurs when the counter reaches 0.
- Transaction latency: request seen in IDLE to Done = SETUP_CYC+EN_CYC+HOLD_CYC cycles after the grant cycle. Minimum per-transaction period = 1+SETUP_CYC+EN_CYC+HOLD_CYC.
- Req, Wdata and Waddr are sampled only in IDLE. Changes during a transaction are ignored.
- A requester dropping Req mid-transaction does not abort it; Done is still pulsed.
- A requester holding Req after its Done is re-arbitrated in the next IDLE cycle. Other pending requesters win first under round-robin; if it is the only one pending, it receives a duplicate write. Requesters deassert Req in the cycle after Done.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness: no requester waits more than N_REQ-1 transactions.
- Reset asserted mid-transaction: no Done is issued. The affected latch word holds whatever was latched before En fell.

Test Plan:
- Reset then single write (defaults): Req=4'b0001, Wdata[7:0]=8'hA5, Waddr[1:0]=2'd2 at cycle 0.
  - Grant=0001 and Latch_D=A5 from cycle 1.
  - Latch_En=4'b0100 in cycles 2-3.
  - Done[0] pulse in cycle 4; Busy low at cycle 5.
- All four requesters assert Req together, each holding Req until its own Done: grants occur in order 0,1,2,3, with each Grant period 4 cycles and an IDLE cycle between grants. Done pulses at cycles 4, 9, 14, 19.
- Round-robin wrap: after granting requester 3, requesters 0 and 3 both request. Requester 0 is granted first.
- Stability check across any random traffic (assertions):
  - Latch_D never changes while Latch_En != 0, nor in the cycle after Latch_En falls.
  - Latch_En is always one-hot or zero.
  - Grant is always one-hot or zero.
- Input change mid-transaction: change Wdata to 8'h3C and drop Req during ENABLE. Latch_D stays A5 and Done is still pulsed.
- Reset mid-ENABLE: assert Reset during the first ENABLE cycle. Latch_En and Grant go to 0 in the same cycle (asynchronously), no Done is issued, and after Reset is released the pointer is 0 and the next grant goes to requester 0.
